// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler that owns HI/LO and models op latency.
// Ports: clk, reset (async, low), E_start/E_op/E_v1/E_v2 from E-stage,
// D_md_use from D-stage, md_busy/md_stall to hazard logic, md_hi/md_lo out.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [2:0]  E_op,
  input  logic [31:0] E_v1,
  input  logic [31:0] E_v2,
  input  logic        D_md_use,
  output logic        md_busy,
  output logic        md_stall,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] pend_hi, pend_hi_n;
  logic [31:0] pend_lo, pend_lo_n;
  logic        pend_wr, pend_wr_n;
  logic [31:0] hi_n, lo_n;

  logic is_mul, is_div, is_mthi, is_mtlo, sgn;

  assign is_mul  = (E_op[2:1] == 2'd0);
  assign is_div  = (E_op[2:1] == 2'd1);
  assign is_mthi = (E_op == 3'd4);
  assign is_mtlo = (E_op == 3'd5);
  assign sgn     = ~E_op[0];

  logic [63:0] ea, eb, prod;

  // Extension picks signedness; the low 64 bits are right for both.
  assign ea   = sgn ? {{32{E_v1[31]}}, E_v1} : {32'b0, E_v1};
  assign eb   = sgn ? {{32{E_v2[31]}}, E_v2} : {32'b0, E_v2};
  assign prod = ea * eb;

  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, dvs, uq, ur, quo, rem;

  // Signed divide on magnitudes: quotient truncates toward zero and
  // the remainder follows the dividend. 0x80000000/-1 wraps to itself.
  assign neg_a = sgn & E_v1[31];
  assign neg_b = sgn & E_v2[31];
  assign mag_a = neg_a ? -E_v1 : E_v1;
  assign mag_b = neg_b ? -E_v2 : E_v2;
  assign dvs   = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign uq    = mag_a / dvs;
  assign ur    = mag_a % dvs;
  assign quo   = (neg_a ^ neg_b) ? -uq : uq;
  assign rem   = neg_a ? -ur : ur;

  assign md_busy  = (state == RUN);
  assign md_stall = D_md_use & (E_start | md_busy);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_wr_n = pend_wr;
    hi_n      = md_hi;
    lo_n      = md_lo;
    case (state)
      IDLE: begin
        if (E_start) begin
          unique case (1'b1)
            is_mul: begin
              pend_hi_n = prod[63:32];
              pend_lo_n = prod[31:0];
              pend_wr_n = 1'b1;
              cnt_n     = 4'(MULT_CYCLES);
              state_n   = RUN;
            end
            is_div: begin
              pend_hi_n = rem;
              pend_lo_n = quo;
              pend_wr_n = |E_v2;
              cnt_n     = 4'(DIV_CYCLES);
              state_n   = RUN;
            end
            is_mthi: hi_n = E_v1;
            is_mtlo: lo_n = E_v1;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = IDLE;
          if (pend_wr) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      md_hi   <= 32'd0;
      md_lo   <= 32'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_wr <= pend_wr_n;
      md_hi   <= hi_n;
      md_lo   <= lo_n;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed and randomized checks of md_sched against
// an arithmetic reference model of HI/LO and busy latency.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_start;
  logic [2:0]  E_op;
  logic [31:0] E_v1, E_v2;
  logic        D_md_use;
  logic        md_busy, md_stall;
  logic [31:0] md_hi, md_lo;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .E_start(E_start), .E_op(E_op), .E_v1(E_v1), .E_v2(E_v2),
    .D_md_use(D_md_use),
    .md_busy(md_busy), .md_stall(md_stall),
    .md_hi(md_hi), .md_lo(md_lo)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    E_start = 1'b1; E_op = op; E_v1 = a; E_v2 = b;
    @(posedge clk); #1;
    E_start = 1'b0; E_v1 = $urandom; E_v2 = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (md_busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  // Reference: what HI/LO become and how long the unit stays busy.
  task automatic model(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int cyc);
    longint p, sa, sb, q, r;
    logic [63:0] up;
    cyc = 0;
    case (op)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        exp_hi = p[63:32]; exp_lo = p[31:0]; cyc = 5;
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        exp_hi = up[63:32]; exp_lo = up[31:0]; cyc = 5;
      end
      3'd2: begin
        cyc = 10;
        if (b != 0) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          exp_lo = q[31:0]; exp_hi = r[31:0];
        end
      end
      3'd3: begin
        cyc = 10;
        if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endtask

  task automatic test_reset;
    D_md_use = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", md_busy); end
    total++; if (md_hi !== 32'd0) begin bad++; $display("FAIL rst_hi got=%h exp=0", md_hi); end
    total++; if (md_lo !== 32'd0) begin bad++; $display("FAIL rst_lo got=%h exp=0", md_lo); end
    total++; if (md_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", md_stall); end
    reset = 1'b1;
    D_md_use = 1'b0;
    issue(3'd4, 32'h12345678, 32'd0);
    issue(3'd0, 32'd5, 32'd6);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    D_md_use = 1'b1;
    #1;
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", md_busy); end
    total++; if (md_hi !== 32'd0) begin bad++; $display("FAIL midrst_hi got=%h exp=0", md_hi); end
    total++; if (md_lo !== 32'd0) begin bad++; $display("FAIL midrst_lo got=%h exp=0", md_lo); end
    total++; if (md_stall !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%b exp=0", md_stall); end
    #3 reset = 1'b1;
    D_md_use = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL postrst_busy got=%b exp=0", md_busy); end
    total++; if (md_hi !== 32'd0) begin bad++; $display("FAIL postrst_hi got=%h exp=0", md_hi); end
    total++; if (md_lo !== 32'd0) begin bad++; $display("FAIL postrst_lo got=%h exp=0", md_lo); end
  endtask

  task automatic test_mult;
    int n;
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    total++; if (md_lo !== 32'd0) begin bad++; $display("FAIL mult_early_lo got=%h exp=0", md_lo); end
    wait_done(n);
    total++; if (n != 5) begin bad++; $display("FAIL mult_busy got=%0d exp=5", n); end
    total++; if (md_hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", md_hi); end
    total++; if (md_lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffa", md_lo); end
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    wait_done(n);
    total++; if (n != 5) begin bad++; $display("FAIL multu_busy got=%0d exp=5", n); end
    total++; if (md_hi !== 32'h2) begin bad++; $display("FAIL multu_hi got=%h exp=2", md_hi); end
    total++; if (md_lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffa", md_lo); end
  endtask

  task automatic test_div;
    int n;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(n);
    total++; if (n != 10) begin bad++; $display("FAIL div_busy got=%0d exp=10", n); end
    total++; if (md_lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", md_lo); end
    total++; if (md_hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", md_hi); end
    issue(3'd3, 32'd7, 32'd2);
    wait_done(n);
    total++; if (md_lo !== 32'd3) begin bad++; $display("FAIL divu_lo got=%h exp=3", md_lo); end
    total++; if (md_hi !== 32'd1) begin bad++; $display("FAIL divu_hi got=%h exp=1", md_hi); end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    total++; if (md_lo !== 32'h80000000) begin bad++; $display("FAIL divovf_lo got=%h exp=80000000", md_lo); end
    total++; if (md_hi !== 32'd0) begin bad++; $display("FAIL divovf_hi got=%h exp=0", md_hi); end
  endtask

  task automatic test_divzero;
    int n;
    issue(3'd4, 32'h11111111, 32'd0);
    issue(3'd5, 32'h22222222, 32'd0);
    total++; if (md_hi !== 32'h11111111) begin bad++; $display("FAIL mthi got=%h exp=11111111", md_hi); end
    total++; if (md_lo !== 32'h22222222) begin bad++; $display("FAIL mtlo got=%h exp=22222222", md_lo); end
    issue(3'd3, 32'd5, 32'd0);
    wait_done(n);
    total++; if (n != 10) begin bad++; $display("FAIL dz_busy got=%0d exp=10", n); end
    total++; if (md_hi !== 32'h11111111) begin bad++; $display("FAIL dz_hi got=%h exp=11111111", md_hi); end
    total++; if (md_lo !== 32'h22222222) begin bad++; $display("FAIL dz_lo got=%h exp=22222222", md_lo); end
  endtask

  task automatic test_stall;
    int n;
    D_md_use = 1'b1;
    E_start = 1'b1; E_op = 3'd0; E_v1 = 32'd6; E_v2 = 32'd7;
    #1;
    total++; if (md_stall !== 1'b1) begin bad++; $display("FAIL stall_start got=%b exp=1", md_stall); end
    @(posedge clk); #1;
    E_start = 1'b0;
    n = 0;
    while (md_busy === 1'b1 && n < 40) begin
      n++;
      if (n == 2) begin
        E_start = 1'b1; E_op = 3'd2; E_v1 = 32'd100; E_v2 = 32'd3;
      end else begin
        E_start = 1'b0;
      end
      #1;
      total++; if (md_stall !== 1'b1) begin bad++; $display("FAIL stall_busy cyc=%0d got=%b exp=1", n, md_stall); end
      @(posedge clk); #1;
    end
    E_start = 1'b0;
    #1;
    total++; if (n != 5) begin bad++; $display("FAIL stall_len got=%0d exp=5", n); end
    total++; if (md_stall !== 1'b0) begin bad++; $display("FAIL stall_after got=%b exp=0", md_stall); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL ign_busy got=%b exp=0", md_busy); end
    total++; if (md_hi !== 32'd0) begin bad++; $display("FAIL ign_hi got=%h exp=0", md_hi); end
    total++; if (md_lo !== 32'd42) begin bad++; $display("FAIL ign_lo got=%h exp=2a", md_lo); end
    D_md_use = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    issue(3'd5, 32'hDEADBEEF, 32'd0);
    total++; if (md_lo !== 32'hDEADBEEF) begin bad++; $display("FAIL mtlo2 got=%h exp=deadbeef", md_lo); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL mtlo_busy got=%b exp=0", md_busy); end
    issue(3'd0, 32'd3, 32'd4);
    wait_done(n);
    total++; if (md_lo !== 32'd12) begin bad++; $display("FAIL b2b_lo1 got=%h exp=c", md_lo); end
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", md_busy); end
    wait_done(n);
    total++; if (n != 5) begin bad++; $display("FAIL b2b_len got=%0d exp=5", n); end
    total++; if (md_hi !== 32'd1) begin bad++; $display("FAIL b2b_hi got=%h exp=1", md_hi); end
    total++; if (md_lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL b2b_lo got=%h exp=fffffffe", md_lo); end
  endtask

  task automatic test_random;
    int n, cyc;
    logic [2:0] op;
    logic [31:0] a, b;
    model(3'd4, 32'h0BADF00D, 32'd0, cyc);
    issue(3'd4, 32'h0BADF00D, 32'd0);
    model(3'd5, 32'hC0FFEE00, 32'd0, cyc);
    issue(3'd5, 32'hC0FFEE00, 32'd0);
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: ;
      endcase
      model(op, a, b, cyc);
      issue(op, a, b);
      wait_done(n);
      total++; if (n != cyc) begin bad++; $display("FAIL rnd_busy i=%0d op=%0d got=%0d exp=%0d", i, op, n, cyc); end
      total++; if (md_hi !== exp_hi) begin bad++; $display("FAIL rnd_hi i=%0d op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, md_hi, exp_hi); end
      total++; if (md_lo !== exp_lo) begin bad++; $display("FAIL rnd_lo i=%0d op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, md_lo, exp_lo); end
    end
  endtask

  initial begin
    reset = 1'b0;
    E_start = 1'b0; E_op = 3'd0; E_v1 = 32'd0; E_v2 = 32'd0;
    D_md_use = 1'b0;
    test_reset;
    test_mult;
    test_div;
    test_divzero;
    test_stall;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler for the five-stage MIPS pipeline. It sits beside the E-stage ALU and owns the HI/LO registers.
- It accepts mult/multu/div/divu/mthi/mtlo from E and models the operation latency with a down-counter.
- It raises a stall toward the hazard logic while a D-stage instruction needs the unit and the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  active-low asynchronous reset
- E_start  in  1  E-stage instruction is a valid md-class op this cycle
- E_op  in  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6-7 reserved
- E_v1  in  32  rs operand, already forwarded
- E_v2  in  32  rt operand, already forwarded
- D_md_use  in  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- md_busy  out  1  unit is computing
- md_stall  out  1  freezes D, bubbles E: D_md_use & (E_start | md_busy)
- md_hi  out  32  HI register
- md_lo  out  32  LO register

Behaviour:
- Reset (reset=0, asynchronous): md_hi=0, md_lo=0, md_busy=0, cnt=0, pend_hi=0, pend_lo=0, pend_wr=0. md_stall is combinational and becomes 0 once md_busy=0 and the inputs are quiet.
- States:
  - IDLE: cnt==0, md_busy=0
  - RUN: cnt>0, md_busy=1
- IDLE, edge with E_start=1 and E_op in 0..3:
  - Compute the result into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES for ops 0-1, DIV_CYCLES for ops 2-3.
  - Go to RUN.
  - md_hi/md_lo stay unchanged at this edge.
- RUN, each edge: cnt<=cnt-1. At the edge where cnt==1:
  - md_hi<=pend_hi and md_lo<=pend_lo, if pend_wr.
  - md_busy falls at this same edge.
  - md_busy is therefore high for exactly N cycles after the start edge.
  - The new HI/LO is visible in the cycle md_busy is first 0.
- Arithmetic:
  - mult: signed 32x32 product to 64 bits; {hi,lo}=product.
  - multu: unsigned 32x32 product to 64 bits.
  - div: lo=quotient, hi=remainder, truncated toward zero; remainder takes the dividend's sign.
  - divu: unsigned quotient/remainder.
- Divide by zero (E_v2==0, op 2 or 3): pend_wr=0, so HI/LO are unchanged. Full DIV_CYCLES busy time still elapses.
- Overflow case (div 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- mthi/mtlo (op 4/5) in IDLE: md_hi<=E_v1 (or md_lo<=E_v1) at the next edge. Not busy; no cnt load.
- E_start while RUN (any op): ignored, state untouched. md_stall prevents this in a correct pipeline; the bench checks that it is ignored.
- Reserved ops 6-7: no effect.
- Back-to-back: a start presented in the first IDLE cycle after RUN is accepted normally.
- Reset asserted mid-RUN: aborts immediately, HI/LO cleared, pending result discarded.
- md_stall is purely combinational: no register on this path.
- md_hi/md_lo are registered outputs; mfhi/mflo read them directly.
- Implementation: pend_* and cnt are registers. Operands are sampled only at the start edge; the E_v1/E_v2 values after that edge are don't-care.

Test Plan:
- Reset low mid-operation, then release → all outputs 0, md_busy=0 within the reset cycle, no stray HI/LO write afterward.
- mult E_v1=0xFFFFFFFE (-2), E_v2=3 → md_busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu → hi=0x00000002, lo=0xFFFFFFFA.
- div -7 by 2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7 by 2 → lo=3, hi=1.
- divu 5 by 0 with hi/lo preset to 0x11111111/0x22222222 via mthi/mtlo → busy 10 cycles, values unchanged.
- D_md_use=1 during RUN → md_stall=1 every busy cycle and 0 the cycle after the fall. Second E_start issued mid-RUN → ignored; HI/LO equal the first op's result.
- mtlo 0xDEADBEEF in IDLE → lo updates next edge, md_busy stays 0. mult started the cycle after RUN ends → accepted, busy reasserts next cycle.
